// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - Run monitor for the mips_cpu observation ports: cycle count, halt/watchdog detection, PC trace.
module mips_run_monitor #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 4,
    parameter int TRACE_DEPTH = 8,
    localparam int PTR_W      = $clog2(TRACE_DEPTH),
    localparam int TC_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_alu,
    output logic [TC_W-1:0]   trace_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [ADDR_W-1:0] halt_pc
);
    localparam int RPT_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TC_W-1:0]    tcount_q, tcount_d;
    logic [RPT_W-1:0]   rep_q, rep_d;
    logic [ADDR_W-1:0]  prev_pc_q, prev_pc_d;
    logic               prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0]  halt_pc_q, halt_pc_d;
    logic [ADDR_W-1:0]  rd_pc_q;
    logic [DATA_W-1:0]  rd_alu_q;
    logic               trace_we;

    logic [ADDR_W-1:0]  trace_pc  [TRACE_DEPTH];
    logic [DATA_W-1:0]  trace_alu [TRACE_DEPTH];

    logic [PTR_W-1:0]   rd_ptr;
    logic               rd_hit;

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        wr_ptr_d     = wr_ptr_q;
        tcount_d     = tcount_q;
        rep_d        = rep_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        halt_pc_d    = halt_pc_q;
        trace_we     = 1'b0;
        if (state_q == ST_RUN && en) begin
            cycle_d = cycle_q + CNT_W'(1);
            if (!prev_valid_q || pc_in != prev_pc_q) begin
                trace_we = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (tcount_q != TC_W'(TRACE_DEPTH)) begin
                    tcount_d = tcount_q + TC_W'(1);
                end
                rep_d = '0;
            end else begin
                rep_d = rep_q + RPT_W'(1);
                if (rep_d == RPT_W'(HALT_REPEAT)) begin
                    state_d   = ST_HALTED;
                    halt_pc_d = pc_in;
                end
            end
            prev_pc_d    = pc_in;
            prev_valid_d = 1'b1;
            // A halt on the same cycle as the watchdog limit takes priority.
            if (cycle_d == CNT_W'(MAX_CYCLES) && state_d != ST_HALTED) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    assign rd_ptr = wr_ptr_q - PTR_W'(1) - rd_idx;
    assign rd_hit = {1'b0, rd_idx} < tcount_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cycle_q      <= '0;
            wr_ptr_q     <= '0;
            tcount_q     <= '0;
            rep_q        <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            halt_pc_q    <= '0;
            rd_pc_q      <= '0;
            rd_alu_q     <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            wr_ptr_q     <= wr_ptr_d;
            tcount_q     <= tcount_d;
            rep_q        <= rep_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            halt_pc_q    <= halt_pc_d;
            rd_pc_q      <= rd_hit ? trace_pc[rd_ptr]  : '0;
            rd_alu_q     <= rd_hit ? trace_alu[rd_ptr] : '0;
        end
    end

    // Stale entries need no clearing: reads beyond tcount_q are masked to zero.
    always_ff @(posedge clk) begin
        if (reset && trace_we) begin
            trace_pc[wr_ptr_q]  <= pc_in;
            trace_alu[wr_ptr_q] <= alu_in;
        end
    end

    assign rd_pc       = rd_pc_q;
    assign rd_alu      = rd_alu_q;
    assign trace_count = tcount_q;
    assign cycle_count = cycle_q;
    assign running     = (state_q == ST_RUN);
    assign done        = (state_q == ST_HALTED);
    assign timed_out   = (state_q == ST_TIMEOUT);
    assign halt_pc     = halt_pc_q;
endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - Self-checking bench for mips_run_monitor against a history-list reference model.
module tb_mips_run_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic [2:0]  rd_idx;

    logic [31:0] o_rd_pc   [3];
    logic [31:0] o_rd_alu  [3];
    logic [31:0] o_halt_pc [3];
    logic [3:0]  o_tc      [3];
    logic [15:0] o_cyc     [3];
    logic        o_run     [3];
    logic        o_done    [3];
    logic        o_to      [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_run_monitor #(
            .ADDR_W(32), .DATA_W(32), .CNT_W(16),
            .MAX_CYCLES((g == 0) ? 1000 : (g == 1) ? 20 : 9),
            .HALT_REPEAT(4), .TRACE_DEPTH(8)
        ) u_dut (
            .clk(clk), .reset(reset), .en(en), .pc_in(pc_in), .alu_in(alu_in),
            .rd_idx(rd_idx), .rd_pc(o_rd_pc[g]), .rd_alu(o_rd_alu[g]),
            .trace_count(o_tc[g]), .cycle_count(o_cyc[g]), .running(o_run[g]),
            .done(o_done[g]), .timed_out(o_to[g]), .halt_pc(o_halt_pc[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: state 0=run 1=halted 2=timeout; trace is the full list of PC changes.
    int          m_max [3] = '{1000, 20, 9};
    int          m_st  [3];
    int          m_cyc [3];
    int          m_rep [3];
    bit          m_pv  [3];
    logic [31:0] m_ppc [3];
    logic [31:0] m_hpc [3];
    int          m_n   [3];
    logic [63:0] m_hist [3][4096];
    logic [63:0] m_rd  [3];

    function automatic logic [63:0] model_read(input int k, input int idx);
        int cnt;
        cnt = (m_n[k] < 8) ? m_n[k] : 8;
        if (idx >= cnt) return 64'd0;
        return m_hist[k][(m_n[k] - 1 - idx) % 4096];
    endfunction

    function automatic void model_step(input int k);
        bit halted_now;
        if (!reset) begin
            m_st[k] = 0; m_cyc[k] = 0; m_rep[k] = 0; m_pv[k] = 0;
            m_ppc[k] = '0; m_hpc[k] = '0; m_n[k] = 0;
            return;
        end
        if (m_st[k] != 0 || !en) return;
        m_cyc[k]++;
        halted_now = 0;
        if (!m_pv[k] || pc_in != m_ppc[k]) begin
            m_hist[k][m_n[k] % 4096] = {pc_in, alu_in};
            m_n[k]++;
            m_rep[k] = 0;
        end else begin
            m_rep[k]++;
            if (m_rep[k] == 4) begin
                m_st[k] = 1; m_hpc[k] = pc_in; halted_now = 1;
            end
        end
        m_ppc[k] = pc_in;
        m_pv[k]  = 1;
        if (!halted_now && m_cyc[k] == m_max[k]) m_st[k] = 2;
    endfunction

    task automatic step(input logic r, input logic e, input logic [31:0] pc,
                        input logic [31:0] alu, input int idx);
        reset = r; en = e; pc_in = pc; alu_in = alu; rd_idx = 3'(idx);
        for (int k = 0; k < 3; k++) m_rd[k] = r ? model_read(k, idx) : 64'd0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("u%0d_rd_pc", k),   o_rd_pc[k],   m_rd[k][63:32]);
            check_eq($sformatf("u%0d_rd_alu", k),  o_rd_alu[k],  m_rd[k][31:0]);
            check_eq($sformatf("u%0d_trace_count", k), o_tc[k], (m_n[k] < 8) ? m_n[k] : 8);
            check_eq($sformatf("u%0d_cycle_count", k), o_cyc[k], m_cyc[k]);
            check_eq($sformatf("u%0d_running", k),   o_run[k],  m_st[k] == 0);
            check_eq($sformatf("u%0d_done", k),      o_done[k], m_st[k] == 1);
            check_eq($sformatf("u%0d_timed_out", k), o_to[k],   m_st[k] == 2);
            check_eq($sformatf("u%0d_halt_pc", k),   o_halt_pc[k], m_hpc[k]);
        end
    endtask

    logic [31:0] t1_pcs [9] = '{0, 4, 8, 12, 16, 16, 16, 16, 16};

    initial begin
        logic [31:0] pc;
        int hold_prob, seg_len, r;
        reset = 1'b0; en = 1'b0; pc_in = '0; alu_in = '0; rd_idx = '0;
        @(negedge clk);

        // Straight-line code then jump-to-self; MAX_CYCLES=9 instance sees halt and timeout together.
        step(1'b0, 1'b0, 0, 0, 0);
        check_eq("reset_running", o_run[0], 1);
        check_eq("reset_cycle", o_cyc[0], 0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, t1_pcs[i], t1_pcs[i] * 3 + 1, 0);
            if (i == 7) check_eq("t1_done_early", o_done[0], 0);
        end
        check_eq("t1_done", o_done[0], 1);
        check_eq("t1_halt_pc", o_halt_pc[0], 16);
        check_eq("t1_cycle", o_cyc[0], 9);
        check_eq("t1_trace_count", o_tc[0], 5);
        check_eq("t1_rd_pc0", o_rd_pc[0], 16);
        check_eq("t1_timed_out", o_to[0], 0);
        check_eq("t5_done", o_done[2], 1);
        check_eq("t5_timed_out", o_to[2], 0);

        // Reset while halted discards everything.
        step(1'b0, 1'b1, 16, 0, 0);
        check_eq("t6_running", o_run[0], 1);
        check_eq("t6_done", o_done[0], 0);
        check_eq("t6_cycle", o_cyc[0], 0);
        check_eq("t6_trace_count", o_tc[0], 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 0, 0, i);
            check_eq($sformatf("t6_rd_pc_%0d", i), o_rd_pc[0], 0);
        end

        // Watchdog: PC never repeats.
        step(1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 32'(i * 4), 32'(i), 0);
            if (i == 18) check_eq("t2_timed_out_early", o_to[1], 0);
            if (i == 19) begin
                check_eq("t2_timed_out", o_to[1], 1);
                check_eq("t2_cycle", o_cyc[1], 20);
                check_eq("t2_running", o_run[1], 0);
                check_eq("t2_done", o_done[1], 0);
            end
        end

        // Trace wrap: 12 distinct PCs then halt at 44, then sweep the read index.
        step(1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 44, 32'hDEAD_0000, 0);
        check_eq("t3_done", o_done[0], 1);
        check_eq("t3_trace_count", o_tc[0], 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 44, 0, i);
            check_eq($sformatf("t3_rd_pc_%0d", i), o_rd_pc[0], 32'(44 - 4 * i));
            check_eq($sformatf("t3_rd_alu_%0d", i), o_rd_alu[0], 32'(44 - 4 * i) ^ 32'hA5A5_0000);
        end

        // en toggling: identical result after 9 enabled cycles; disabled cycles carry junk PCs.
        step(1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, $urandom, $urandom, 0);
            if (i == 8) check_eq("t4_done_early", o_done[0], 0);
            step(1'b1, 1'b1, t1_pcs[i], t1_pcs[i] * 3 + 1, 0);
        end
        check_eq("t4_done", o_done[0], 1);
        check_eq("t4_cycle", o_cyc[0], 9);
        check_eq("t4_halt_pc", o_halt_pc[0], 16);
        check_eq("t4_trace_count", o_tc[0], 5);

        // Randomized segments.
        for (int s = 0; s < 10; s++) begin
            step(1'b0, 1'b0, 0, 0, 0);
            hold_prob = $urandom_range(1, 7);
            seg_len   = $urandom_range(30, 200);
            pc = 32'($urandom_range(0, 63)) << 2;
            for (int c = 0; c < seg_len; c++) begin
                r = $urandom_range(0, 9);
                if (r == 9) pc = 32'($urandom_range(0, 63)) << 2;
                else if (r >= hold_prob) pc = pc + 4;
                step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
                     pc, $urandom, $urandom_range(0, 7));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Synthesizable run monitor attached to the mips_cpu observation ports (pc_out, alu_result).
- Counts executed cycles and detects program completion as a PC that stays unchanged, e.g. a jump-to-self halt loop.
- Flags a watchdog timeout if completion does not occur in time.
- Keeps a circular trace of the most recent PC changes, readable through a registered read port. Benches and FPGA debug logic use it instead of fixed-length runs.

Parameters:
- ADDR_W, 32, width of the PC sample.
- DATA_W, 32, width of the ALU result sample.
- CNT_W, 16, width of the cycle counter.
- MAX_CYCLES, 1000, watchdog limit in enabled cycles; must be less than 2^CNT_W.
- HALT_REPEAT, 4, consecutive enabled cycles with an unchanged PC that declare a halt; must be at least 1.
- TRACE_DEPTH, 8, number of trace entries; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; active when 0, sampled on the clk rising edge.
- en  in  1  sample enable; when 0, no counting, halt tracking or trace writes occur.
- pc_in  in  ADDR_W  CPU PC (pc_out).
- alu_in  in  DATA_W  CPU ALU result (alu_result).
- rd_idx  in  log2(TRACE_DEPTH)  trace read index; 0 is the newest entry.
- rd_pc  out  ADDR_W  registered trace PC at rd_idx.
- rd_alu  out  DATA_W  registered trace ALU value at rd_idx.
- trace_count  out  log2(TRACE_DEPTH)+1  valid trace entries; saturates at TRACE_DEPTH.
- cycle_count  out  CNT_W  enabled cycles spent in RUN.
- running  out  1  state is RUN.
- done  out  1  halt detected; sticky.
- timed_out  out  1  watchdog fired; sticky.
- halt_pc  out  ADDR_W  PC captured at halt.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to RUN.
  - All outputs clear to 0; running is the exception and goes to 1.
  - Trace pointer clears, prev_valid clears, repeat counter clears.
  - Reset applied mid-run or in a terminal state discards everything, with no partial retention.
- States: RUN, HALTED, TIMEOUT.
  - HALTED and TIMEOUT are terminal until reset.
  - In a terminal state, counters and the trace freeze, but the trace stays readable.
- RUN, enabled cycle (en=1), in this order:
  1. cycle_count increments by 1.
  2. If prev_valid=0 or pc_in != prev_pc:
     - Write {pc_in, alu_in} into the trace at the write pointer.
     - Advance the pointer, wrapping modulo TRACE_DEPTH and overwriting the oldest entry when full.
     - trace_count increments, saturating at TRACE_DEPTH.
     - Repeat counter clears to 0.
  3. Otherwise repeat counter increments; at the transition where it reaches HALT_REPEAT, go to HALTED and set halt_pc = pc_in.
  4. prev_pc <= pc_in; prev_valid <= 1.
  5. If the incremented cycle_count equals MAX_CYCLES and no halt fired this cycle, go to TIMEOUT.
- Simultaneous halt and timeout in the same cycle: HALTED wins; done=1, timed_out=0.
- Terminal-state outputs:
  - done=1 exactly when in HALTED; timed_out=1 exactly when in TIMEOUT.
  - Both change on the same edge as the state; running drops on that same edge.
- en=0 cycles are invisible: no counter, repeat or trace change, and prev_pc holds.
- Trace read:
  - rd_pc/rd_alu update one cycle after rd_idx, from the entry at (wr_ptr - 1 - rd_idx) mod TRACE_DEPTH.
  - Entries with rd_idx >= trace_count read as 0.
  - A trace write and a read of the same entry in the same cycle return the pre-write contents.
- Arithmetic: all pointer arithmetic is unsigned modulo TRACE_DEPTH. cycle_count never wraps, because RUN exits at MAX_CYCLES.

Test Plan:
- Reset then straight-line PCs 0,4,8,12 followed by a jump-to-self holding PC=16, with en=1 and HALT_REPEAT=4:
  - PC=16 is first seen at cycle 5 and repeats on cycles 6-9.
  - done=1 after cycle 9, halt_pc=16, cycle_count=9, trace_count=5, rd_idx=0 returns PC 16, timed_out=0.
- Incrementing PC forever with MAX_CYCLES=20: timed_out=1 after the 20th enabled cycle, cycle_count=20, running=0, done=0.
- 12 distinct PCs 0..44 with TRACE_DEPTH=8, then halt:
  - trace_count=8.
  - rd_idx=0 returns PC 44 with its alu value; rd_idx=7 returns PC 16. PCs 0..12 are overwritten.
  - Each rd_idx change is reflected one cycle later.
- en toggled 0/1 every other cycle during the first test's sequence: the same results as the first test occur, but done asserts only after 9 enabled cycles.
- Set MAX_CYCLES=9 with the first test's PC sequence: halt and timeout coincide, and the required result is done=1, timed_out=0.
- Assert reset=0 for one cycle while HALTED:
  - Next cycle shows running=1, done=0, cycle_count=0, trace_count=0.
  - rd_pc reads 0 for all indices.
